// File: rtl/main_result_checker.sv
// Reads NUM_WORDS result words back from main's slave port 0 after done_port, checks
// non-decreasing signed order, counts violations and sums a 32-bit wrap-around checksum.
// Per element: 1 issue + D wait + 1 accumulate cycles; +1 report cycle. Waits up to TIMEOUT per read.
module main_result_checker #(
  parameter int BASE_ADDR  = 0,
  parameter int NUM_WORDS  = 100,
  parameter int ELEM_BYTES = 4,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 64,
  parameter int SIZE_W     = 7,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  done_port,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  check_done,
  output logic                  check_pass,
  output logic [15:0]           viol_count,
  output logic [31:0]           checksum,
  output logic                  timeout_err
);

  localparam int ELEM_W = 8 * ELEM_BYTES;
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [SIZE_W-1:0] ELEM_SIZE = SIZE_W'(ELEM_W);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, REPORT} state_t;

  state_t              state, state_n;
  logic                done_prev;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [CNT_W-1:0]    wait_cnt, wait_cnt_n;
  logic [ELEM_W-1:0]   elem, elem_n;
  logic [ELEM_W-1:0]   prev, prev_n;
  logic [15:0]         viol, viol_n;
  logic [31:0]         csum, csum_n;
  logic                tmo, tmo_n;
  logic                pass, pass_n;
  logic                start;
  logic                oe, oe_n;
  logic                rpt, rpt_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [SIZE_W-1:0]   size, size_n;
  logic [31:0]         addr_full;

  // Channel 1, the upper data bits and DataRdy[1] are never looked at.
  logic unused_in;
  assign unused_in = ^{Sout_Rdata_ram[2*DATA_W-1:ELEM_W], Sout_DataRdy[1]};

  assign start = done_port && !done_prev && (state == IDLE);

  // Next-state, datapath updates and next values of the registered slave-port outputs.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    wait_cnt_n = wait_cnt;
    elem_n     = elem;
    prev_n     = prev;
    viol_n     = viol;
    csum_n     = csum;
    tmo_n      = tmo;
    pass_n     = pass;
    addr_full  = 32'd0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          idx_n   = '0;
          viol_n  = 16'd0;
          csum_n  = 32'd0;
          tmo_n   = 1'b0;
          pass_n  = 1'b0;
        end
      end
      ISSUE: begin
        state_n    = WAIT;
        wait_cnt_n = '0;
      end
      WAIT: begin
        if (Sout_DataRdy[0]) begin
          elem_n  = Sout_Rdata_ram[ELEM_W-1:0];
          state_n = ACC;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
          if (wait_cnt_n == CNT_LIMIT) begin
            tmo_n   = 1'b1;
            state_n = REPORT;
          end
        end
      end
      ACC: begin
        csum_n = csum + 32'(elem);
        if ((idx != '0) && ($signed(elem) < $signed(prev)) && (viol != 16'hFFFF))
          viol_n = viol + 16'd1;
        prev_n = elem;
        if (idx == LAST_IDX) begin
          state_n = REPORT;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = ISSUE;
        end
      end
      REPORT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // The verdict is latched on entry to REPORT so it is valid alongside check_done.
    if (state_n == REPORT)
      pass_n = (viol_n == 16'd0) && !tmo_n;
    addr_full = 32'(BASE_ADDR) + 32'(idx_n) * 32'(ELEM_BYTES);
    oe_n   = (state_n == ISSUE);
    rpt_n  = (state_n == REPORT);
    addr_n = (state_n == ISSUE) ? addr_full[ADDR_W-1:0] : '0;
    size_n = ((state_n == ISSUE) || (state_n == WAIT)) ? ELEM_SIZE : '0;
  end

  // State, datapath and output registers; reset aborts any run in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done_prev <= 1'b0;
      idx       <= '0;
      wait_cnt  <= '0;
      elem      <= '0;
      prev      <= '0;
      viol      <= 16'd0;
      csum      <= 32'd0;
      tmo       <= 1'b0;
      pass      <= 1'b0;
      oe        <= 1'b0;
      rpt       <= 1'b0;
      addr      <= '0;
      size      <= '0;
    end else begin
      state     <= state_n;
      done_prev <= done_port;
      idx       <= idx_n;
      wait_cnt  <= wait_cnt_n;
      elem      <= elem_n;
      prev      <= prev_n;
      viol      <= viol_n;
      csum      <= csum_n;
      tmo       <= tmo_n;
      pass      <= pass_n;
      oe        <= oe_n;
      rpt       <= rpt_n;
      addr      <= addr_n;
      size      <= size_n;
    end
  end

  assign S_oe_ram        = {1'b0, oe};
  assign S_we_ram        = 2'b00;
  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr};
  assign S_Wdata_ram     = '0;
  assign S_data_ram_size = {{SIZE_W{1'b0}}, size};
  assign check_done      = rpt;
  assign check_pass      = pass;
  assign viol_count      = viol;
  assign checksum        = csum;
  assign timeout_err     = tmo;

endmodule

// File: tb/tb_main_result_checker.sv
module tb_main_result_checker;
  localparam int BASE = 16;
  localparam int NW   = 4;
  localparam int AW   = 7;
  localparam int DW   = 64;
  localparam int SW   = 7;
  localparam int TMO  = 20;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              done_port = 1'b0;
  logic [1:0]        S_oe_ram, S_we_ram;
  logic [2*AW-1:0]   S_addr_ram;
  logic [2*DW-1:0]   S_Wdata_ram;
  logic [2*SW-1:0]   S_data_ram_size;
  logic [2*DW-1:0]   Sout_Rdata_ram = '0;
  logic [1:0]        Sout_DataRdy = 2'b00;
  logic              check_done, check_pass, timeout_err;
  logic [15:0]       viol_count;
  logic [31:0]       checksum;

  main_result_checker #(
    .BASE_ADDR(BASE), .NUM_WORDS(NW), .ELEM_BYTES(4), .ADDR_W(AW),
    .DATA_W(DW), .SIZE_W(SW), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .check_done(check_done), .check_pass(check_pass), .viol_count(viol_count),
    .checksum(checksum), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mem [NW];
  int          rdy_delay = 2;
  int          stall_idx = -1;
  int          cd = 0;
  logic [31:0] pend_data = 32'd0;
  int          run_issue = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          first_oe_cyc = 0;
  int          last_oe_cyc = 0;
  int          done_cyc = 0;

  typedef struct {
    logic [31:0] m0, m1, m2, m3;
    int          d;
    logic        pass;
    logic [15:0] viol;
    logic [31:0] sum;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slave memory model: answers each read D cycles after oe, and monitors check_done.
  always @(negedge clock) begin
    cyc++;
    if (check_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    Sout_DataRdy   = 2'b00;
    Sout_Rdata_ram = {64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 32'h5555_AAAA};
    if (!reset) begin
      cd = 0;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        Sout_DataRdy   = 2'b11;
        Sout_Rdata_ram = {64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, pend_data};
      end
    end
    if (S_oe_ram[0]) begin
      check("oe_fields",
            {96'd0, |S_Wdata_ram, S_oe_ram[1], S_we_ram, S_addr_ram[2*AW-1:AW],
             S_data_ram_size[2*SW-1:SW], S_addr_ram[AW-1:0], S_data_ram_size[SW-1:0]},
            {96'd0, 18'd0, AW'(BASE + 4 * run_issue), SW'(32)});
      if (run_issue == 0) first_oe_cyc = cyc;
      last_oe_cyc = cyc;
      if (run_issue != stall_idx && run_issue < NW) begin
        cd        = rdy_delay;
        pend_data = mem[run_issue];
      end
      run_issue++;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic load(input vec_t v);
    mem[0] = v.m0; mem[1] = v.m1; mem[2] = v.m2; mem[3] = v.m3;
    rdy_delay = v.d;
  endtask

  task automatic start_run();
    run_issue = 0;
    done_port = 1'b1;
    tick();
    done_port = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == c0; i++) tick();
    if (done_cnt == c0) check("done_wait_budget", 128'd0, 128'd1);
  endtask

  initial begin
    int c0;
    vecs[0] = '{32'd1, 32'd2, 32'd2, 32'd7, 2, 1'b1, 16'd0, 32'd12};
    vecs[1] = '{32'd5, 32'd3, 32'd4, 32'hFFFF_FFFF, 1, 1'b0, 16'd2, 32'd11};
    vecs[2] = '{32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd0, 32'h7FFF_FFFF, 3, 1'b1, 16'd0, 32'h7FFF_FFF5};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b1, 16'd0, 32'hFFFF_FFFC};
    vecs[4] = '{32'd3, 32'd2, 32'd1, 32'd0, 1, 1'b0, 16'd3, 32'd6};
    vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0, 4, 1'b0, 16'd1, 32'hFFFF_FFFF};

    // Reset state
    repeat (3) tick();
    check("reset_outputs",
          {47'd0, S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size, check_done, check_pass,
           viol_count, checksum, timeout_err}, 128'd0);
    check("reset_wdata", S_Wdata_ram, 128'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Table-driven runs
    for (int v = 0; v < 6; v++) begin
      load(vecs[v]);
      stall_idx = -1;
      c0 = done_cnt;
      start_run();
      wait_done(300);
      check("pass",    check_pass,  vecs[v].pass);
      check("viol",    viol_count,  vecs[v].viol);
      check("sum",     checksum,    vecs[v].sum);
      check("tmo",     timeout_err, 1'b0);
      check("issues",  run_issue,   NW);
      check("latency", done_cyc - first_oe_cyc, NW * (vecs[v].d + 2));
      repeat (3) tick();
      check("hold", {check_done, check_pass, viol_count, checksum},
            {1'b0, vecs[v].pass, vecs[v].viol, vecs[v].sum});
      check("one_done", done_cnt - c0, 1);
    end

    // Read of idx 2 never answered
    load('{32'd1, 32'd2, 32'd3, 32'd4, 2, 1'b0, 16'd0, 32'd0});
    stall_idx = 2;
    start_run();
    wait_done(300);
    check("tmo_err",     timeout_err, 1'b1);
    check("tmo_pass",    check_pass,  1'b0);
    check("tmo_sum",     checksum,    32'd3);
    check("tmo_latency", done_cyc - last_oe_cyc, TMO + 1);
    repeat (5) tick();
    check("tmo_issues",  run_issue,   3);
    stall_idx = -1;

    // done_port held high, then pulsed again mid-run: one run only
    load(vecs[1]);
    c0 = done_cnt;
    run_issue = 0;
    done_port = 1'b1;
    repeat (3) tick();
    done_port = 1'b0;
    repeat (3) tick();
    done_port = 1'b1;
    tick();
    done_port = 1'b0;
    wait_done(300);
    repeat (40) tick();
    check("held_done_cnt", done_cnt - c0, 1);
    check("held_issues",   run_issue, NW);
    check("held_viol",     viol_count, 16'd2);
    check("held_tmo_clr",  timeout_err, 1'b0);
    // A fresh edge in IDLE starts a run with cleared counters
    load(vecs[0]);
    start_run();
    wait_done(300);
    check("rerun_viol", viol_count, 16'd0);
    check("rerun_pass", check_pass, 1'b1);
    check("rerun_sum",  checksum,   32'd12);

    // Reset while waiting on idx 1
    load(vecs[1]);
    rdy_delay = 3;
    start_run();
    for (int i = 0; i < 50 && run_issue < 2; i++) tick();
    tick();
    reset = 1'b0;
    #1;
    check("midreset_outputs",
          {47'd0, S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size, check_done, check_pass,
           viol_count, checksum, timeout_err}, 128'd0);
    c0 = done_cnt;
    repeat (5) tick();
    reset = 1'b1;
    repeat (10) tick();
    check("midreset_no_done", done_cnt - c0, 0);
    load(vecs[0]);
    start_run();
    wait_done(300);
    check("after_reset_pass",   check_pass, 1'b1);
    check("after_reset_sum",    checksum,   32'd12);
    check("after_reset_issues", run_issue,  NW);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
